// File: rtl/music_player_seq.sv
// music_player_seq
//   Song sequencer. It walks a song in music memory one 32-bit word at a time.
//   Each word is played for BEAT_CYCLES clocks as a note code. While a note is
//   playing, a square wave is generated whose half-period is
//   TONE_SCALE*(9-note) clocks.
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   start         one-cycle request to play song song_sel (honoured in IDLE only)
//   stop          abort playback; takes priority over every other transition
//   song_sel      song index; the song base address is song_sel*0x200
//   memreq_val    memory request valid (FETCH state only)
//   memreq_addr   word-aligned byte address; 0 when no request is made
//   memresp_data  combinational memory response for memreq_addr
//   note          current note code (0 = rest); nonzero only while playing a word
//   note_val      high while a memory word is being played
//   playing       high in every state except IDLE
//   done          one-cycle pulse on natural song completion
//   audio_out     square-wave tone for the current note
module music_player_seq #(
   parameter int unsigned BEAT_CYCLES = 1000,
   parameter int unsigned TONE_SCALE  = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic [4:0]  song_sel,
   output logic        memreq_val,
   output logic [15:0] memreq_addr,
   input  logic [31:0] memresp_data,
   output logic [2:0]  note,
   output logic        note_val,
   output logic        playing,
   output logic        done,
   output logic        audio_out
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_PLAY  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [4:0]  r_song;
   logic [8:0]  r_offset;
   logic [19:0] r_beat;
   logic [2:0]  r_note;
   logic [15:0] r_tone;
   logic        r_audio;

   logic        w_song_end;
   logic        w_beat_done;
   logic        w_last_word;
   logic        w_start_ok;
   logic [2:0]  w_fetch_note;

   // Reload value for the tone half-period counter: TONE_SCALE*(9-n) - 1.
   function automatic logic [15:0] half_m1(input logic [2:0] n);
      int unsigned h;
      h = TONE_SCALE * (32'd9 - 32'(n));
      return 16'(h - 32'd1);
   endfunction

   always_comb begin
      w_song_end   = (memresp_data == 32'hFFFF_FFFF);
      // Only 0..7 are note codes; any other word plays as a rest.
      w_fetch_note = (memresp_data[31:3] == '0) ? memresp_data[2:0] : 3'd0;
      w_beat_done  = (r_beat == '0);
      w_last_word  = (r_offset == 9'h1FC);
      w_start_ok   = start && !stop;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and state-decoded outputs
   always_comb begin
      w_next      = r_state;
      memreq_val  = 1'b0;
      memreq_addr = '0;
      note_val    = 1'b0;
      playing     = 1'b1;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            playing = 1'b0;
            if (w_start_ok) begin
               w_next = S_FETCH;
            end
         end
         S_FETCH: begin
            memreq_val = 1'b1;
            // The base is song*0x200 and the offset is below 0x200, so the sum
            // reduces to a concatenation.
            memreq_addr = {2'b00, r_song, r_offset};
            if (stop) begin
               w_next = S_IDLE;
            end else if (w_song_end) begin
               w_next = S_DONE;
            end else begin
               w_next = S_PLAY;
            end
         end
         S_PLAY: begin
            note_val = 1'b1;
            if (stop) begin
               w_next = S_IDLE;
            end else if (w_beat_done) begin
               w_next = w_last_word ? S_DONE : S_FETCH;
            end
         end
         S_DONE: begin
            done   = !stop;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Datapath: song latch, word offset, beat and tone counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_song   <= '0;
         r_offset <= '0;
         r_beat   <= '0;
         r_note   <= '0;
         r_tone   <= '0;
         r_audio  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_song   <= song_sel;
                  r_offset <= '0;
               end
            end
            S_FETCH: begin
               if (!stop && !w_song_end) begin
                  r_note  <= w_fetch_note;
                  r_beat  <= 20'(BEAT_CYCLES - 32'd1);
                  r_tone  <= half_m1(w_fetch_note);
                  r_audio <= 1'b0;
               end
            end
            S_PLAY: begin
               if (stop || w_beat_done) begin
                  // Leaving PLAY in any direction silences the output.
                  r_note  <= '0;
                  r_audio <= 1'b0;
                  if (!stop && !w_last_word) begin
                     r_offset <= r_offset + 9'd4;
                  end
               end else begin
                  r_beat <= r_beat - 20'd1;
                  if (r_note != 3'd0) begin
                     if (r_tone == '0) begin
                        r_audio <= ~r_audio;
                        r_tone  <= half_m1(r_note);
                     end else begin
                        r_tone <= r_tone - 16'd1;
                     end
                  end
               end
            end
            default: begin
               r_note  <= '0;
               r_audio <= 1'b0;
            end
         endcase
      end
   end

   assign note      = r_note;
   assign audio_out = r_audio;

endmodule

// File: tb/tb_music_player_seq.sv
// tb_music_player_seq
//   Directed bench for music_player_seq with BEAT_CYCLES=4, TONE_SCALE=1. The
//   music memory is a small behavioural table: song 0 holds a short tune, song 2
//   is empty, and song 17 is a full song ending at its last word. A second
//   memory mode returns note 2 everywhere and never ends a song.
module tb_music_player_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic        stop;
   logic [4:0]  song_sel;
   logic        memreq_val;
   logic [15:0] memreq_addr;
   logic [31:0] memresp_data;
   logic [2:0]  note;
   logic        note_val;
   logic        playing;
   logic        done;
   logic        audio_out;

   bit          mem_mode;
   int unsigned n_total;
   int unsigned n_bad;

   music_player_seq #(
      .BEAT_CYCLES(4),
      .TONE_SCALE (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .song_sel    (song_sel),
      .memreq_val  (memreq_val),
      .memreq_addr (memreq_addr),
      .memresp_data(memresp_data),
      .note        (note),
      .note_val    (note_val),
      .playing     (playing),
      .done        (done),
      .audio_out   (audio_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_rd(input logic [15:0] a, input bit m);
      logic [6:0] idx;
      idx = a[8:2];
      if (m) return 32'd2;
      case (a[15:9])
         7'd0: begin
            case (a[8:0])
               9'h000:  return 32'd3;
               9'h004:  return 32'h1234_5678;
               9'h008:  return 32'd7;
               9'h00C:  return 32'd6;
               9'h010:  return 32'd1;
               9'h014:  return 32'd5;
               default: return 32'hFFFF_FFFF;
            endcase
         end
         7'd17:   return (a[8:0] == 9'h1FC) ? 32'hFFFF_FFFF : (32'(idx) % 32'd7) + 32'd1;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   always_comb memresp_data = mem_rd(memreq_addr, mem_mode);

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk_eq({tag, "_playing"}, {31'd0, playing}, 32'd0);
      chk_eq({tag, "_note"}, {29'd0, note}, 32'd0);
      chk_eq({tag, "_note_val"}, {31'd0, note_val}, 32'd0);
      chk_eq({tag, "_audio"}, {31'd0, audio_out}, 32'd0);
      chk_eq({tag, "_done"}, {31'd0, done}, 32'd0);
      chk_eq({tag, "_memreq_val"}, {31'd0, memreq_val}, 32'd0);
      chk_eq({tag, "_memreq_addr"}, {16'd0, memreq_addr}, 32'd0);
   endtask

   // Expects the current cycle to be the FETCH of addr; it then checks the four
   // PLAY cycles (pattern bit i is audio_out in PLAY cycle i) and returns
   // positioned on the cycle that follows the last PLAY cycle.
   task automatic play_entry(input string tag, input logic [15:0] addr,
                             input logic [2:0] exp_note, input logic [3:0] pat);
      chk_eq({tag, "_fetch_val"}, {31'd0, memreq_val}, 32'd1);
      chk_eq({tag, "_fetch_addr"}, {16'd0, memreq_addr}, {16'd0, addr});
      chk_eq({tag, "_fetch_note"}, {29'd0, note}, 32'd0);
      chk_eq({tag, "_fetch_nv"}, {31'd0, note_val}, 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk_eq({tag, "_note"}, {29'd0, note}, {29'd0, exp_note});
         chk_eq({tag, "_nv"}, {31'd0, note_val}, 32'd1);
         chk_eq({tag, "_audio"}, {31'd0, audio_out}, {31'd0, pat[i]});
         chk_eq({tag, "_noreq"}, {31'd0, memreq_val}, 32'd0);
         tick();
      end
   endtask

   task automatic run_song(input logic [4:0] sel, input int unsigned budget,
                           output int unsigned entries, output logic [15:0] last_addr,
                           output int unsigned dones, output int unsigned note_errs,
                           output int unsigned stray, output int unsigned fall_errs,
                           output bit ended);
      logic [15:0] fa;
      logic [31:0] w;
      logic [2:0]  en;
      bit          prev_nv;
      bit          prev_done;
      entries   = 0;
      last_addr = '0;
      dones     = 0;
      note_errs = 0;
      stray     = 0;
      fall_errs = 0;
      ended     = 1'b0;
      fa        = '0;
      prev_nv   = 1'b0;
      prev_done = 1'b0;
      song_sel  = sel;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      for (int unsigned c = 0; c < budget; c++) begin
         if (memreq_val) begin
            last_addr = memreq_addr;
            fa        = memreq_addr;
            if (memreq_addr[15:9] != {2'b00, sel}) stray++;
         end
         if (note_val && !prev_nv) begin
            entries++;
            w  = mem_rd(fa, mem_mode);
            en = (w[31:3] == '0) ? w[2:0] : 3'd0;
            if (note !== en) note_errs++;
         end
         if (done) dones++;
         if (prev_done && playing) fall_errs++;
         if (!playing) begin
            if (!prev_done) fall_errs++;
            ended = 1'b1;
            break;
         end
         prev_nv   = note_val;
         prev_done = done;
         tick();
      end
   endtask

   int unsigned ent;
   int unsigned dn;
   int unsigned nerr;
   int unsigned str;
   int unsigned ferr;
   logic [15:0] la;
   bit          fin;

   initial begin
      n_total  = 0;
      n_bad    = 0;
      mem_mode = 1'b0;
      rst      = 1'b1;
      start    = 1'b0;
      stop     = 1'b0;
      song_sel = '0;
      tick();
      tick();
      chk_quiet("reset");
      rst = 1'b0;
      tick();
      chk_quiet("idle");

      // V1 plus tone checks: song 0; song_sel changes after start are ignored.
      song_sel = 5'd0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      song_sel = 5'd2;
      chk_eq("v1_playing", {31'd0, playing}, 32'd1);
      play_entry("v1_e0", 16'h0000, 3'd3, 4'b0000);
      play_entry("v1_e1", 16'h0004, 3'd0, 4'b0000);
      play_entry("v6_f",  16'h0008, 3'd7, 4'b1100);
      play_entry("v6_e",  16'h000C, 3'd6, 4'b1000);
      play_entry("v6_g",  16'h0010, 3'd1, 4'b0000);
      play_entry("v1_e5", 16'h0014, 3'd5, 4'b0000);
      chk_eq("v1_end_val", {31'd0, memreq_val}, 32'd1);
      chk_eq("v1_end_addr", {16'd0, memreq_addr}, 32'h0018);
      tick();
      chk_eq("v1_done", {31'd0, done}, 32'd1);
      chk_eq("v1_done_nv", {31'd0, note_val}, 32'd0);
      tick();
      chk_quiet("v1_after");

      // V2: empty song.
      song_sel = 5'd2;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      chk_eq("v2_addr", {16'd0, memreq_addr}, 32'h0400);
      chk_eq("v2_val", {31'd0, memreq_val}, 32'd1);
      tick();
      chk_eq("v2_done", {31'd0, done}, 32'd1);
      chk_eq("v2_nv", {31'd0, note_val}, 32'd0);
      chk_eq("v2_playing", {31'd0, playing}, 32'd1);
      tick();
      chk_quiet("v2_after");

      // V3: song 17 to its end.
      run_song(5'd17, 2000, ent, la, dn, nerr, str, ferr, fin);
      chk_eq("v3_ended", {31'd0, fin}, 32'd1);
      chk_eq("v3_entries", ent, 32'd127);
      chk_eq("v3_last_addr", {16'd0, la}, 32'h23FC);
      chk_eq("v3_dones", dn, 32'd1);
      chk_eq("v3_note_errs", nerr, 32'd0);
      chk_eq("v3_stray", str, 32'd0);
      chk_eq("v3_fall", ferr, 32'd0);

      // V4: memory without SONG_END; the offset must not wrap into song 1.
      mem_mode = 1'b1;
      run_song(5'd0, 2000, ent, la, dn, nerr, str, ferr, fin);
      chk_eq("v4_ended", {31'd0, fin}, 32'd1);
      chk_eq("v4_entries", ent, 32'd128);
      chk_eq("v4_last_addr", {16'd0, la}, 32'h01FC);
      chk_eq("v4_dones", dn, 32'd1);
      chk_eq("v4_note_errs", nerr, 32'd0);
      chk_eq("v4_stray", str, 32'd0);
      chk_eq("v4_fall", ferr, 32'd0);
      mem_mode = 1'b0;
      tick();

      // V5: start ignored while playing, then stop in the 2nd PLAY cycle.
      song_sel = 5'd0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      tick();
      chk_eq("v5_p0_note", {29'd0, note}, 32'd3);
      song_sel = 5'd2;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      chk_eq("v5_p1_note", {29'd0, note}, 32'd3);
      chk_eq("v5_p1_nv", {31'd0, note_val}, 32'd1);
      chk_eq("v5_p1_noreq", {31'd0, memreq_val}, 32'd0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk_quiet("v5_stop");
      tick();
      chk_quiet("v5_stop2");
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      chk_quiet("v5_both");

      // V6: reset in the middle of note F while the tone is high.
      song_sel = 5'd0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      for (int i = 0; i < 13; i++) tick();
      chk_eq("v6_pre_note", {29'd0, note}, 32'd7);
      chk_eq("v6_pre_audio", {31'd0, audio_out}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_quiet("v6_rst");
      tick();
      chk_quiet("v6_rst2");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
